rams64_byte_port: RTL and testbench

Sequencing controller that drives a 64x1 single-port distributed RAM primitive. The primitive has an asynchronous read, a synchronous write, and separate ADR0..ADR5, I, WE, O pins. This block exposes the RAM as eight 8-bit words behind valid/ready request and response channels. Each request is serialised into single-bit RAM accesses: read, write, or full-array clear. It sits between the RAM primitive and any byte-oriented client logic.

---
 rtl/rams64_byte_port.sv | 127 ++++++++++++
 tb/tb_rams64_byte_port.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rams64_byte_port.sv
// Byte-wide request/response front end for a 64x1 distributed RAM.
// Each request is serialised into one-bit RAM accesses (read, write or clear).
module rams64_byte_port #(
  parameter logic CLR_VAL = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [1:0] REQ_OP,
  input  logic [2:0] REQ_WADR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_DATA,
  output logic       RSP_ERR,
  output logic [5:0] RAM_ADR,
  output logic       RAM_WE,
  output logic       RAM_I,
  input  logic       RAM_O
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_CLEAR,
    S_RESP
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] wadr_q, wadr_d;
  logic [7:0] data_q, data_d;
  logic       err_q, err_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wadr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wadr_q  <= wadr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wadr_d  = wadr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          wadr_d = REQ_WADR;
          cnt_d  = '0;
          err_d  = 1'b0;
          data_d = 8'h00;
          case (REQ_OP)
            2'b00: state_d = S_READ;
            2'b01: begin
              data_d  = REQ_DATA;
              state_d = S_WRITE;
            end
            2'b10: state_d = S_CLEAR;
            default: begin
              err_d   = 1'b1;
              state_d = S_RESP;
            end
          endcase
        end
      end
      S_READ: begin
        data_d[cnt_q[2:0]] = RAM_O;
        if (cnt_q[2:0] == 3'd7) state_d = S_RESP;
        else                    cnt_d   = cnt_q + 6'd1;
      end
      S_WRITE: begin
        if (cnt_q[2:0] == 3'd7) state_d = S_RESP;
        else                    cnt_d   = cnt_q + 6'd1;
      end
      S_CLEAR: begin
        if (cnt_q == 6'd63) state_d = S_RESP;
        else                cnt_d   = cnt_q + 6'd1;
      end
      S_RESP: begin
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are gated by RST so nothing is written or presented on the reset edge.
  always_comb begin
    REQ_READY = (state_q == S_IDLE) && !RST;
    RSP_VALID = (state_q == S_RESP) && !RST;
    RSP_DATA  = RST ? 8'h00 : data_q;
    RSP_ERR   = err_q && !RST;
    RAM_ADR   = '0;
    RAM_WE    = 1'b0;
    RAM_I     = 1'b0;
    if (!RST) begin
      case (state_q)
        S_READ: RAM_ADR = {wadr_q, cnt_q[2:0]};
        S_WRITE: begin
          RAM_ADR = {wadr_q, cnt_q[2:0]};
          RAM_WE  = 1'b1;
          RAM_I   = data_q[cnt_q[2:0]];
        end
        S_CLEAR: begin
          RAM_ADR = cnt_q;
          RAM_WE  = 1'b1;
          RAM_I   = CLR_VAL;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rams64_byte_port.sv
// Directed bench for rams64_byte_port with a behavioural 64x1 RAM attached.
module tb_rams64_byte_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [2:0] req_wadr = 3'd0;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [5:0] ram_adr;
  logic       ram_we;
  logic       ram_i;
  logic       ram_o;

  logic [63:0] mem = 64'hDEAD_BEEF_0123_4567;
  int          cyc = 0;
  int          we_cnt = 0;
  logic [5:0]  we_adr_q[$];
  logic        we_bit_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  rams64_byte_port #(.CLR_VAL(1'b0)) dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_OP(req_op),
    .REQ_WADR(req_wadr), .REQ_DATA(req_data),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
    .RAM_ADR(ram_adr), .RAM_WE(ram_we), .RAM_I(ram_i), .RAM_O(ram_o)
  );

  assign ram_o = mem[ram_adr];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_adr] <= ram_i;
  end
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt <= we_cnt + 1;
      we_adr_q.push_back(ram_adr);
      we_bit_q.push_back(ram_i);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Issue one request, measure latency (edges from accept to first edge with
  // RSP_VALID seen), optionally stall the response, then complete the handshake.
  task automatic do_req(input logic [1:0] op, input logic [2:0] wadr, input logic [7:0] data,
                        input int stall, output logic [7:0] rdata, output logic err,
                        output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_wadr = wadr; req_data = data;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    rdata = rsp_data;
    err   = rsp_err;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data", {24'd0, rsp_data}, {24'd0, rdata});
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_after_rsp", {30'd0, req_ready, rsp_valid}, 32'd2);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] wadr;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_lat;
    int         exp_we;
    int         stall;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] rd;
    logic       er;
    int         lat;
    int         we0;
    logic [7:0] pat;
    int         acc_t[2];
    int         n_acc;

    vecs.push_back('{2'b01, 3'd3, 8'hA5, 8'hA5, 1'b0, 9, 8, 0});
    vecs.push_back('{2'b00, 3'd3, 8'h00, 8'hA5, 1'b0, 9, 0, 0});
    vecs.push_back('{2'b01, 3'd0, 8'hFF, 8'hFF, 1'b0, 9, 8, 0});
    vecs.push_back('{2'b01, 3'd7, 8'hFF, 8'hFF, 1'b0, 9, 8, 0});
    vecs.push_back('{2'b10, 3'd5, 8'h77, 8'h00, 1'b0, 65, 64, 0});
    for (int w = 0; w < 8; w++)
      vecs.push_back('{2'b00, 3'(w), 8'h00, 8'h00, 1'b0, 9, 0, 0});
    vecs.push_back('{2'b11, 3'd2, 8'h5A, 8'h00, 1'b1, 1, 0, 0});
    vecs.push_back('{2'b01, 3'd5, 8'h96, 8'h96, 1'b0, 9, 8, 0});
    vecs.push_back('{2'b00, 3'd5, 8'h00, 8'h96, 1'b0, 9, 0, 5});
    vecs.push_back('{2'b01, 3'd2, 8'h3C, 8'h3C, 1'b0, 9, 8, 0});
    vecs.push_back('{2'b00, 3'd2, 8'h00, 8'h3C, 1'b0, 9, 0, 0});
    vecs.push_back('{2'b01, 3'd1, 8'h00, 8'h00, 1'b0, 9, 8, 0});

    // Reset values, then first cycle with RST low.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
    chk("rst_ram", {24'd0, ram_adr, ram_we, ram_i}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    we_adr_q.delete();
    we_bit_q.delete();
    foreach (vecs[i]) begin
      we0 = we_cnt;
      do_req(vecs[i].op, vecs[i].wadr, vecs[i].data, vecs[i].stall, rd, er, lat);
      chk($sformatf("v%0d_data", i), {24'd0, rd}, {24'd0, vecs[i].exp_data});
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_we", i), we_cnt - we0, vecs[i].exp_we);
      if (i == 0) begin
        pat = 8'hA5;
        chk("a5_we_len", we_adr_q.size(), 32'd8);
        for (int j = 0; j < 8 && j < we_adr_q.size(); j++) begin
          chk($sformatf("a5_adr%0d", j), {26'd0, we_adr_q[j]}, 32'(24 + j));
          chk($sformatf("a5_bit%0d", j), {31'd0, we_bit_q[j]}, {31'd0, pat[j]});
        end
      end
    end

    // Reset on the fifth write cycle: bits 0..3 land, 4..7 keep their old value.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_wadr = 3'd1; req_data = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_we", {31'd0, ram_we}, 32'd0);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_mem", {24'd0, mem[15:8]}, 32'h0F);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    do_req(2'b00, 3'd1, 8'h00, 0, rd, er, lat);
    chk("rst_mid_read", {24'd0, rd}, 32'h0F);

    // Back-to-back with REQ_VALID and RSP_READY held high.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_wadr = 3'd6; req_data = 8'h3C;
    rsp_ready = 1'b1;
    n_acc = 0;
    acc_t[0] = 0; acc_t[1] = 0;
    for (int c = 0; c < 100 && n_acc < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (n_acc == 1) req_op = 2'b00;
      if (req_ready) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
    end
    chk("b2b_accepts", n_acc, 32'd2);
    chk("b2b_period", acc_t[1] - acc_t[0], 32'd10);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("b2b_read", {24'd0, rsp_data}, 32'h3C);
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
